// File: rtl/window_generator_3x3.sv
// 3x3 sliding window over a raster-order 4-bit pixel stream.
// Two line buffers hold the previous two lines. A 3x3 register array shifts
// one column per accepted pixel. win_valid marks windows whose centre lies
// fully inside the frame, so a window never spans a line or frame wrap.
module window_generator_3x3 #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       pix_valid,
   input  logic [3:0] pix_in,
   output logic [3:0] p00,
   output logic [3:0] p01,
   output logic [3:0] p02,
   output logic [3:0] p10,
   output logic [3:0] p11,
   output logic [3:0] p12,
   output logic [3:0] p20,
   output logic [3:0] p21,
   output logic [3:0] p22,
   output logic       win_valid,
   output logic [9:0] win_x,
   output logic [9:0] win_y
);

   localparam int         AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [9:0] LAST_COL = 10'(IMG_WIDTH - 1);
   localparam logic [9:0] LAST_ROW = 10'(IMG_HEIGHT - 1);

   logic [9:0]    col_q, col_d;
   logic [9:0]    row_q, row_d;
   logic [9:0]    cur_col, cur_row;
   logic          accept;
   logic          centre_ok;
   logic [AW-1:0] addr;
   logic [3:0]    rd0, rd1;

   logic [3:0]    line0_mem [IMG_WIDTH];
   logic [3:0]    line1_mem [IMG_WIDTH];

   logic [3:0]    win_q [3][3];
   logic          win_valid_q, win_valid_d;
   logic [9:0]    win_x_q, win_y_q;

   // Coordinate of the pixel on the input this cycle; frame_start forces (0,0).
   always_comb begin
      accept    = pix_valid;
      cur_col   = frame_start ? '0 : col_q;
      cur_row   = frame_start ? '0 : row_q;
      addr      = cur_col[AW-1:0];
      centre_ok = (cur_col >= 10'd2) && (cur_row >= 10'd2);
      rd0       = line0_mem[addr];
      rd1       = line1_mem[addr];
   end

   // Next raster position after the current pixel, wrapping at line and frame end.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (cur_col == LAST_COL) begin
            col_d = '0;
            row_d = (cur_row == LAST_ROW) ? '0 : cur_row + 10'd1;
         end else begin
            col_d = cur_col + 10'd1;
            row_d = cur_row;
         end
      end
   end

   // Raster position counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // Line buffers: read-before-write, line1 ages into line0 at the same column.
   always_ff @(posedge clk) begin
      if (accept) begin
         line0_mem[addr] <= line1_mem[addr];
         line1_mem[addr] <= pix_in;
      end
   end

   // Window shift register: newest column enters at index 2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 3; i++) begin
            for (int unsigned j = 0; j < 3; j++) begin
               win_q[i][j] <= '0;
            end
         end
      end else if (accept) begin
         for (int unsigned i = 0; i < 3; i++) begin
            win_q[i][0] <= win_q[i][1];
            win_q[i][1] <= win_q[i][2];
         end
         win_q[0][2] <= rd0;
         win_q[1][2] <= rd1;
         win_q[2][2] <= pix_in;
      end
   end

   // Valid flag only for interior centres; stale line data from an earlier frame
   // is never flagged because rows 0-1 of a frame never qualify.
   always_comb begin
      win_valid_d = accept && centre_ok;
   end

   // Window-valid pulse and centre coordinate, coordinates held between windows.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_valid_q <= 1'b0;
         win_x_q     <= '0;
         win_y_q     <= '0;
      end else begin
         win_valid_q <= win_valid_d;
         if (win_valid_d) begin
            win_x_q <= cur_col - 10'd1;
            win_y_q <= cur_row - 10'd1;
         end
      end
   end

   assign p00       = win_q[0][0];
   assign p01       = win_q[0][1];
   assign p02       = win_q[0][2];
   assign p10       = win_q[1][0];
   assign p11       = win_q[1][1];
   assign p12       = win_q[1][2];
   assign p20       = win_q[2][0];
   assign p21       = win_q[2][1];
   assign p22       = win_q[2][2];
   assign win_valid = win_valid_q;
   assign win_x     = win_x_q;
   assign win_y     = win_y_q;

endmodule
